// File: rtl/fft_pkg.sv
// Shared FFT definitions: default sizes, the coefficient-reader state
// encoding and the helpers for bus slicing and saturating negation.
package fft_pkg;

  localparam int DEF_NBITS = 5;
  localparam int DEF_N     = 8;
  localparam int DEF_LOG2N = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Low bit of coefficient k on the packed bus (coefficient 0 sits in the MSBs).
  function automatic int coeff_slice(input int k, input int nbits = DEF_NBITS,
                                     input int n = DEF_N);
    return 2 * nbits * (n - 1 - k);
  endfunction

  // Two's-complement negation that maps the most-negative value to the most-positive.
  function automatic int sat_neg(input int x, input int nbits = DEF_NBITS);
    int lo;
    lo = -(1 << (nbits - 1));
    if (x == lo) return -lo - 1;
    return -x;
  endfunction

endpackage

// File: rtl/coeff_reader_if.sv
// Coefficient stream from the reader to the butterfly input stage.
// Handshake: a beat transfers on a rising edge where coeff_valid and
// coeff_ready are both 1. Once coeff_valid rises, it and the payload
// (coeff_re/coeff_im/coeff_idx/coeff_last) stay stable until that transfer;
// coeff_ready may change freely and never depends on coeff_valid.
interface coeff_reader_if #(
  parameter int NBITS = 5,
  parameter int LOG2N = 3
);
  logic             coeff_valid;
  logic             coeff_ready;
  logic [NBITS-1:0] coeff_re;
  logic [NBITS-1:0] coeff_im;
  logic [LOG2N-1:0] coeff_idx;
  logic             coeff_last;

  modport master (
    output coeff_valid, coeff_re, coeff_im, coeff_idx, coeff_last,
    input  coeff_ready
  );

  modport slave (
    input  coeff_valid, coeff_re, coeff_im, coeff_idx, coeff_last,
    output coeff_ready
  );
endinterface

// File: rtl/coeff_unpack.sv
// Combinational selector: picks one complex coefficient out of a packed
// table and optionally conjugates it with saturation on the imaginary part.
module coeff_unpack
  import fft_pkg::*;
#(
  parameter int NBITS = DEF_NBITS,
  parameter int N     = DEF_N,
  parameter int LOG2N = DEF_LOG2N
) (
  input  logic [2*NBITS*N-1:0] tab,
  input  logic [LOG2N-1:0]     idx,
  input  logic                 conj,
  output logic [NBITS-1:0]     re,
  output logic [NBITS-1:0]     im
);

  logic [2*NBITS-1:0] word;
  logic [NBITS-1:0]   im_neg;

  // Slice the addressed entry, split re/im and apply conjugation.
  always_comb begin
    word   = tab[coeff_slice(int'(idx), NBITS, N) +: 2*NBITS];
    re     = word[2*NBITS-1:NBITS];
    im_neg = NBITS'(sat_neg(int'($signed(word[NBITS-1:0])), NBITS));
    im     = conj ? im_neg : word[NBITS-1:0];
  end

endmodule

// File: rtl/coeff_reader.sv
// Coefficient reader: snapshots the packed twiddle table on start and
// streams the entries of the selected FFT stage, one per handshake.
module coeff_reader
  import fft_pkg::*;
#(
  parameter int NBITS = DEF_NBITS,
  parameter int N     = DEF_N,
  parameter int LOG2N = DEF_LOG2N
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2*NBITS*N-1:0] coeff_data,
  input  logic                 start,
  input  logic [LOG2N-1:0]     stride_log2,
  input  logic                 conj,
  output logic                 busy,
  output logic                 done,
  output state_t               dbg_state,
  coeff_reader_if.master       cif
);

  state_t               state_q;
  logic [2*NBITS*N-1:0] snap_q;
  logic [LOG2N-1:0]     s_q;
  logic                 conj_q;
  logic [LOG2N-1:0]     k_q;
  logic [LOG2N-1:0]     last_k_q;

  logic [2*NBITS*N-1:0] src_tab;
  logic                 src_conj;
  logic [LOG2N-1:0]     src_k;
  logic [LOG2N-1:0]     src_s;
  logic [LOG2N-1:0]     src_idx;
  logic [LOG2N-1:0]     last_k_nxt;
  logic [NBITS-1:0]     nxt_re;
  logic [NBITS-1:0]     nxt_im;

  assign dbg_state = state_q;

  // Source of the next output beat: live inputs when launching a burst,
  // otherwise the snapshot and the following index of the running burst.
  always_comb begin
    src_tab    = snap_q;
    src_conj   = conj_q;
    src_k      = k_q + LOG2N'(1);
    src_s      = s_q;
    last_k_nxt = LOG2N'((N >> stride_log2) - 1);
    if (state_q == IDLE) begin
      src_tab  = coeff_data;
      src_conj = conj;
      src_k    = '0;
      src_s    = stride_log2;
    end
    src_idx = src_k << src_s;
  end

  coeff_unpack #(
    .NBITS(NBITS),
    .N    (N),
    .LOG2N(LOG2N)
  ) u_unpack (
    .tab (src_tab),
    .idx (src_idx),
    .conj(src_conj),
    .re  (nxt_re),
    .im  (nxt_im)
  );

  // Burst FSM with counter, snapshot and registered stream outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      snap_q          <= '0;
      s_q             <= '0;
      conj_q          <= 1'b0;
      k_q             <= '0;
      last_k_q        <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      cif.coeff_valid <= 1'b0;
      cif.coeff_re    <= '0;
      cif.coeff_im    <= '0;
      cif.coeff_idx   <= '0;
      cif.coeff_last  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            snap_q          <= coeff_data;
            s_q             <= stride_log2;
            conj_q          <= conj;
            k_q             <= '0;
            last_k_q        <= last_k_nxt;
            busy            <= 1'b1;
            cif.coeff_valid <= 1'b1;
            cif.coeff_re    <= nxt_re;
            cif.coeff_im    <= nxt_im;
            cif.coeff_idx   <= src_idx;
            cif.coeff_last  <= (last_k_nxt == '0);
            state_q         <= STREAM;
          end
        end
        STREAM: begin
          if (cif.coeff_valid && cif.coeff_ready) begin
            if (cif.coeff_last) begin
              cif.coeff_valid <= 1'b0;
              cif.coeff_last  <= 1'b0;
              busy            <= 1'b0;
              done            <= 1'b1;
              state_q         <= DONE;
            end else begin
              k_q            <= src_k;
              cif.coeff_re   <= nxt_re;
              cif.coeff_im   <= nxt_im;
              cif.coeff_idx  <= src_idx;
              cif.coeff_last <= (src_k == last_k_q);
            end
          end
        end
        DONE: begin
          done    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coeff_reader.sv
// Directed bench for coeff_reader: bursts over a known table, checking each
// beat against an expected queue built from the table contents.
module tb_coeff_reader;
  import fft_pkg::*;

  localparam int NB = 5;
  localparam int NN = 8;
  localparam int LG = 3;

  // Clock / reset / DUT
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [2*NB*NN-1:0] coeff_data;
  logic              start;
  logic [LG-1:0]     stride_log2;
  logic              conj;
  logic              busy;
  logic              done;
  state_t            dbg_state;

  coeff_reader_if #(.NBITS(NB), .LOG2N(LG)) cif ();

  coeff_reader #(.NBITS(NB), .N(NN), .LOG2N(LG)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .coeff_data (coeff_data),
    .start      (start),
    .stride_log2(stride_log2),
    .conj       (conj),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state),
    .cif        (cif.master)
  );

  always #5 clk = ~clk;

  // Scoreboard state
  int n_checks = 0;
  int n_errors = 0;
  logic [2*NB+LG:0] exp_q[$];
  int re_t[NN];
  int im_t[NN];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_default_table();
    re_t = '{4, -3, 4, 0, 4, -3, 4, 0};
    im_t = '{0, -3, 0, -4, 0, -3, 0, -4};
  endtask

  function automatic logic [2*NB*NN-1:0] pack_table();
    logic [2*NB*NN-1:0] t;
    logic [31:0] r, i;
    t = '0;
    for (int k = 0; k < NN; k++) begin
      r = re_t[k];
      i = im_t[k];
      t[2*NB*(NN-k)-1 -: 2*NB] = {r[NB-1:0], i[NB-1:0]};
    end
    return t;
  endfunction

  function automatic logic [2*NB+LG:0] observed();
    return {cif.coeff_re, cif.coeff_im, cif.coeff_idx, cif.coeff_last};
  endfunction

  // Expected beats of one burst: index walk, table lookup, saturating conjugate.
  task automatic queue_burst(input int s, input bit cj);
    int burst, idx, imv;
    logic [31:0] r, i;
    logic [LG-1:0] ix;
    burst = NN >> s;
    for (int j = 0; j < burst; j++) begin
      idx = (j << s) % NN;
      imv = im_t[idx];
      if (cj) imv = (imv == -16) ? 15 : -imv;
      r  = re_t[idx];
      i  = imv;
      ix = idx[LG-1:0];
      exp_q.push_back({r[NB-1:0], i[NB-1:0], ix, (j == burst - 1)});
    end
  endtask

  task automatic start_burst(input int s, input bit cj);
    stride_log2 = s[LG-1:0];
    conj        = cj;
    start       = 1'b1;
    check("pre_start_valid", 32'(cif.coeff_valid), 0);
    tick();
    start = 1'b0;
    check("first_valid", 32'(cif.coeff_valid), 1);
    check("busy_on_start", 32'(busy), 1);
  endtask

  // Consume the burst; optional stall at one beat and optional start/data
  // disturbance mid-burst and during DONE.
  task automatic drain(input int stall_beat, input int stall_cycles, input bit poke);
    int beat, stalls, cyc, dones;
    bit fin;
    logic [2*NB+LG:0] e;
    beat = 0; stalls = stall_cycles; cyc = 0; dones = 0; fin = 1'b0;
    while (!fin && cyc < 100) begin
      if (cif.coeff_valid) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 1, 0);
          break;
        end
        e = exp_q[0];
        check($sformatf("beat%0d", beat), 32'(observed()), 32'(e));
        if (beat == stall_beat && stalls > 0) begin
          cif.coeff_ready = 1'b0;
          stalls--;
        end else begin
          cif.coeff_ready = 1'b1;
          void'(exp_q.pop_front());
          fin = e[0];
          beat++;
        end
      end else begin
        check("valid_in_burst", 32'(cif.coeff_valid), 1);
      end
      if (poke && beat == 2 && !fin) begin
        start      = 1'b1;
        coeff_data = ~coeff_data;
      end else begin
        start = 1'b0;
      end
      tick();
      cyc++;
      if (done) dones++;
    end
    if (!fin) check("burst_timeout", 0, 1);
    check("done_pulse", 32'(done), 1);
    check("done_busy", 32'(busy), 0);
    check("done_valid", 32'(cif.coeff_valid), 0);
    check("done_state", 32'(dbg_state), 32'(DONE));
    if (poke) start = 1'b1;
    tick();
    start = 1'b0;
    if (done) dones++;
    check("idle_state", 32'(dbg_state), 32'(IDLE));
    check("idle_valid", 32'(cif.coeff_valid), 0);
    check("idle_busy", 32'(busy), 0);
    check("done_count", 32'(dones), 1);
    check("queue_empty", 32'(exp_q.size()), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(cif.coeff_valid), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_data"}, 32'(observed()), 0);
    check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  initial begin
    start           = 1'b0;
    stride_log2     = '0;
    conj            = 1'b0;
    cif.coeff_ready = 1'b0;
    load_default_table();
    coeff_data = pack_table();
    tick();
    tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // 1: reset in the middle of a burst
    cif.coeff_ready = 1'b1;
    start_burst(0, 1'b0);
    tick();
    tick();
    tick();
    check("pre_reset_idx", 32'(cif.coeff_idx), 3);
    rst_n = 1'b0;
    #1;
    check_all_zero("midburst_reset");
    tick();
    rst_n = 1'b1;
    tick();
    check("post_reset_valid", 32'(cif.coeff_valid), 0);

    // 2: full stage s=0
    queue_burst(0, 1'b0);
    start_burst(0, 1'b0);
    drain(-1, 0, 1'b0);

    // 3: strided stages
    queue_burst(1, 1'b0);
    start_burst(1, 1'b0);
    drain(-1, 0, 1'b0);
    queue_burst(2, 1'b0);
    start_burst(2, 1'b0);
    drain(-1, 0, 1'b0);

    // 4: backpressure for three cycles on beat 1
    queue_burst(0, 1'b0);
    start_burst(0, 1'b0);
    drain(1, 3, 1'b0);

    // 5: conjugation, then saturation on a forced most-negative imag
    queue_burst(0, 1'b1);
    start_burst(0, 1'b1);
    drain(-1, 0, 1'b0);
    im_t[1] = -16;
    coeff_data = pack_table();
    queue_burst(0, 1'b1);
    start_burst(0, 1'b1);
    drain(2, 1, 1'b0);
    load_default_table();
    coeff_data = pack_table();

    // 6: start during burst and DONE, table rewritten mid-burst
    queue_burst(0, 1'b0);
    start_burst(0, 1'b0);
    drain(-1, 0, 1'b1);
    coeff_data = pack_table();
    tick();
    check("final_idle_valid", 32'(cif.coeff_valid), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
